// File: rtl/acmp_frame_parser.sv
// Receive-side ACMP frame parser: hunts for the "ACMP" magic, validates the
// 32-byte header, commits its fields and forwards the payload with a last marker.
module acmp_frame_parser #(
  parameter int          BPP      = 2,
  parameter logic [7:0]  PAD_BYTE = 8'h20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DIN,
  input  logic        DIN_VALID,
  output logic        DIN_READY,
  output logic [7:0]  PIX_DATA,
  output logic        PIX_VALID,
  input  logic        PIX_READY,
  output logic        PIX_LAST,
  output logic [15:0] PARAM_X,
  output logic [15:0] PARAM_Y,
  output logic [15:0] PARAM_ACTIVE_X,
  output logic [15:0] PARAM_ACTIVE_Y,
  output logic [15:0] PARAM_OFFSET_X,
  output logic [15:0] PARAM_OFFSET_Y,
  output logic [5:0]  GAIN,
  output logic [8:0]  OFFSET,
  output logic [31:0] INTEGRATION,
  output logic        HDR_VALID,
  output logic        FRAME_DONE,
  output logic        ERR_HDR,
  output logic [15:0] FRAME_COUNT,
  output logic [15:0] ERR_COUNT
);

  typedef enum logic [1:0] {HUNT, HDR, PAYLOAD} state_t;

  state_t      state, next_state;
  logic [1:0]  match_idx;
  logic [4:0]  pos;
  logic        reject;
  logic [33:0] remaining;
  logic [95:0] sh_geo;
  logic [5:0]  sh_gain;
  logic [8:0]  sh_off;
  logic [31:0] sh_int;

  logic        accept;
  logic        byte_bad;
  logic        hdr_bad;
  logic        magic_hit;
  logic [33:0] frame_len;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h41;
      2'd1:    return 8'h43;
      2'd2:    return 8'h4D;
      default: return 8'h50;
    endcase
  endfunction

  assign accept    = DIN_VALID & DIN_READY;
  assign magic_hit = (DIN == magic_byte(match_idx));
  assign PIX_DATA  = DIN;
  assign frame_len = 34'(sh_geo[47:32]) * 34'(sh_geo[63:48]) * 34'(BPP);
  assign hdr_bad   = reject | byte_bad;

  always_comb begin
    byte_bad = 1'b0;
    if (pos == 5'd16)      byte_bad = (DIN != 8'h00);
    else if (pos == 5'd17) byte_bad = (DIN[7:6] != 2'b00);
    else if (pos == 5'd19) byte_bad = (DIN[7:1] != 7'd0);
    else if (pos >= 5'd24) byte_bad = (DIN != PAD_BYTE);
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    DIN_READY  = 1'b1;
    PIX_VALID  = 1'b0;
    PIX_LAST   = 1'b0;
    case (state)
      HUNT: begin
        if (accept && magic_hit && match_idx == 2'd3) next_state = HDR;
      end
      HDR: begin
        if (accept && pos == 5'd31)
          next_state = (hdr_bad || frame_len == 34'd0) ? HUNT : PAYLOAD;
      end
      PAYLOAD: begin
        DIN_READY = PIX_READY;
        PIX_VALID = DIN_VALID;
        PIX_LAST  = (remaining == 34'd1);
        if (accept && remaining == 34'd1) next_state = HUNT;
      end
      default: next_state = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= HUNT;
    else     state <= next_state;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      match_idx      <= 2'd0;
      pos            <= 5'd0;
      reject         <= 1'b0;
      remaining      <= 34'd0;
      sh_geo         <= '0;
      sh_gain        <= '0;
      sh_off         <= '0;
      sh_int         <= '0;
      PARAM_X        <= '0;
      PARAM_Y        <= '0;
      PARAM_ACTIVE_X <= '0;
      PARAM_ACTIVE_Y <= '0;
      PARAM_OFFSET_X <= '0;
      PARAM_OFFSET_Y <= '0;
      GAIN           <= '0;
      OFFSET         <= '0;
      INTEGRATION    <= '0;
      HDR_VALID      <= 1'b0;
      FRAME_DONE     <= 1'b0;
      ERR_HDR        <= 1'b0;
      FRAME_COUNT    <= '0;
      ERR_COUNT      <= '0;
    end else begin
      HDR_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
      ERR_HDR    <= 1'b0;
      case (state)
        HUNT: if (accept) begin
          if (magic_hit) begin
            if (match_idx == 2'd3) begin
              match_idx <= 2'd0;
              pos       <= 5'd4;
              reject    <= 1'b0;
            end else begin
              match_idx <= match_idx + 2'd1;
            end
          end else begin
            // A stray 'A' may itself start the next magic attempt.
            match_idx <= (DIN == 8'h41) ? 2'd1 : 2'd0;
          end
        end
        HDR: if (accept) begin
          pos    <= pos + 5'd1;
          reject <= hdr_bad;
          if (pos >= 5'd4 && pos <= 5'd15) sh_geo[{pos[3:0] - 4'd4, 3'b000} +: 8] <= DIN;
          if (pos == 5'd17) sh_gain     <= DIN[5:0];
          if (pos == 5'd18) sh_off[7:0] <= DIN;
          if (pos == 5'd19) sh_off[8]   <= DIN[0];
          if (pos >= 5'd20 && pos <= 5'd23) sh_int[{pos[1:0], 3'b000} +: 8] <= DIN;
          if (pos == 5'd31) begin
            if (hdr_bad) begin
              ERR_HDR <= 1'b1;
              if (ERR_COUNT != 16'hFFFF) ERR_COUNT <= ERR_COUNT + 16'd1;
            end else begin
              PARAM_X        <= sh_geo[15:0];
              PARAM_Y        <= sh_geo[31:16];
              PARAM_ACTIVE_X <= sh_geo[47:32];
              PARAM_ACTIVE_Y <= sh_geo[63:48];
              PARAM_OFFSET_X <= sh_geo[79:64];
              PARAM_OFFSET_Y <= sh_geo[95:80];
              GAIN           <= sh_gain;
              OFFSET         <= sh_off;
              INTEGRATION    <= sh_int;
              HDR_VALID      <= 1'b1;
              remaining      <= frame_len;
              if (frame_len == 34'd0) begin
                FRAME_DONE  <= 1'b1;
                FRAME_COUNT <= FRAME_COUNT + 16'd1;
              end
            end
          end
        end
        PAYLOAD: if (accept) begin
          remaining <= remaining - 34'd1;
          if (remaining == 34'd1) begin
            FRAME_DONE  <= 1'b1;
            FRAME_COUNT <= FRAME_COUNT + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acmp_frame_parser.sv
// Directed self-checking bench for acmp_frame_parser: good frame, resync,
// bad pad, backpressure, zero payload and mid-payload reset.
module tb_acmp_frame_parser;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DIN = 8'h00;
  logic        DIN_VALID = 1'b0;
  logic        DIN_READY;
  logic [7:0]  PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic        PIX_LAST;
  logic [15:0] PARAM_X, PARAM_Y, PARAM_ACTIVE_X, PARAM_ACTIVE_Y;
  logic [15:0] PARAM_OFFSET_X, PARAM_OFFSET_Y;
  logic [5:0]  GAIN;
  logic [8:0]  OFFSET;
  logic [31:0] INTEGRATION;
  logic        HDR_VALID, FRAME_DONE, ERR_HDR;
  logic [15:0] FRAME_COUNT, ERR_COUNT;

  acmp_frame_parser #(.BPP(2), .PAD_BYTE(8'h20)) dut (
    .CLK(CLK), .RST(RST),
    .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_LAST(PIX_LAST),
    .PARAM_X(PARAM_X), .PARAM_Y(PARAM_Y),
    .PARAM_ACTIVE_X(PARAM_ACTIVE_X), .PARAM_ACTIVE_Y(PARAM_ACTIVE_Y),
    .PARAM_OFFSET_X(PARAM_OFFSET_X), .PARAM_OFFSET_Y(PARAM_OFFSET_Y),
    .GAIN(GAIN), .OFFSET(OFFSET), .INTEGRATION(INTEGRATION),
    .HDR_VALID(HDR_VALID), .FRAME_DONE(FRAME_DONE), .ERR_HDR(ERR_HDR),
    .FRAME_COUNT(FRAME_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Backpressure pattern applied to PIX_READY, one step per cycle.
  logic       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  initial begin
    int ph = 0;
    PIX_READY = 1'b1;
    forever begin
      @(posedge CLK); #1;
      if (bp_en) begin
        PIX_READY = bp_pat[3 - ph];
        ph = (ph + 1) % 4;
      end else begin
        PIX_READY = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor samples on the falling edge, away from the active edge.
  int   hdr_cnt = 0, done_cnt = 0, err_cnt = 0, same_cnt = 0, beats_at_done = 0;
  logic [7:0] rx_q[$];
  logic       last_q[$];
  always @(negedge CLK) begin
    if (!RST) begin
      if (PIX_VALID && PIX_READY) begin
        rx_q.push_back(PIX_DATA);
        last_q.push_back(PIX_LAST);
      end
      if (HDR_VALID) hdr_cnt++;
      if (FRAME_DONE) begin
        done_cnt++;
        beats_at_done = rx_q.size();
      end
      if (ERR_HDR) err_cnt++;
      if (HDR_VALID && FRAME_DONE) same_cnt++;
    end
  end

  task automatic idle(input int n);
    DIN_VALID = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got = 1'b0;
    DIN = b;
    DIN_VALID = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge CLK);
      got = DIN_READY;
      @(posedge CLK); #1;
    end
    DIN_VALID = 1'b0;
    if (!got) check("send_timeout", 1'b0, 1'b1);
  endtask

  logic [7:0] hb [32];

  task automatic send_frame(input logic [15:0] ax, input logic [15:0] ay,
                            input logic [5:0] gain, input logic [8:0] off,
                            input logic [31:0] integ, input logic [7:0] pad27,
                            input logic [7:0] pay_base, input int npay, input int gap_every);
    hb[0] = 8'h41; hb[1] = 8'h43; hb[2] = 8'h4D; hb[3] = 8'h50;
    {hb[5],  hb[4]}  = 16'd8;
    {hb[7],  hb[6]}  = 16'd8;
    {hb[9],  hb[8]}  = ax;
    {hb[11], hb[10]} = ay;
    {hb[13], hb[12]} = 16'd2;
    {hb[15], hb[14]} = 16'd3;
    hb[16] = 8'h00;
    hb[17] = {2'b00, gain};
    hb[18] = off[7:0];
    hb[19] = {7'd0, off[8]};
    {hb[23], hb[22], hb[21], hb[20]} = integ;
    for (int i = 24; i < 32; i++) hb[i] = 8'h20;
    hb[27] = pad27;
    for (int i = 0; i < 32; i++) send_byte(hb[i]);
    for (int i = 0; i < npay; i++) begin
      send_byte(pay_base + 8'(i));
      if (gap_every > 0 && (i % gap_every) == gap_every - 1) idle(1);
    end
  endtask

  task automatic check_payload(input string tag, input int start, input int n, input logic [7:0] base);
    int lasts = 0;
    check({tag, "_beats"}, rx_q.size() - start, n);
    if (rx_q.size() - start == n) begin
      for (int i = 0; i < n; i++) begin
        check({tag, "_data"}, rx_q[start + i], base + 8'(i));
        if (last_q[start + i]) lasts++;
      end
      check({tag, "_last_count"}, lasts, 1);
      check({tag, "_last_pos"}, last_q[start + n - 1], 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_hdr, b_done, b_err, b_rx, b_same;

    // Reset state
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b0;
    @(negedge CLK);
    check("rst_din_ready", DIN_READY, 1'b1);
    check("rst_pix_valid", PIX_VALID, 1'b0);
    check("rst_frame_count", FRAME_COUNT, 16'd0);
    check("rst_err_count", ERR_COUNT, 16'd0);
    check("rst_param_x", PARAM_X, 16'd0);
    check("rst_pulses", {HDR_VALID, FRAME_DONE, ERR_HDR}, 3'b000);
    @(posedge CLK); #1;

    // Good frame: 4x4x2 = 32 payload bytes
    b_hdr = hdr_cnt; b_done = done_cnt; b_rx = rx_q.size();
    send_frame(16'd4, 16'd4, 6'h15, 9'h10A, 32'd1000000, 8'h20, 8'h00, 32, 0);
    idle(3);
    check("good_hdr_valid", hdr_cnt - b_hdr, 1);
    check("good_x", PARAM_X, 16'd8);
    check("good_y", PARAM_Y, 16'd8);
    check("good_ax", PARAM_ACTIVE_X, 16'd4);
    check("good_ay", PARAM_ACTIVE_Y, 16'd4);
    check("good_ox", PARAM_OFFSET_X, 16'd2);
    check("good_oy", PARAM_OFFSET_Y, 16'd3);
    check("good_gain", GAIN, 6'h15);
    check("good_offset", OFFSET, 9'h10A);
    check("good_integ", INTEGRATION, 32'd1000000);
    check_payload("good", b_rx, 32, 8'h00);
    check("good_done", done_cnt - b_done, 1);
    check("good_frame_count", FRAME_COUNT, 16'd1);

    // Resync through leading garbage; 2x3x2 = 12 payload bytes
    b_hdr = hdr_cnt; b_rx = rx_q.size();
    send_byte(8'h41); send_byte(8'h41); send_byte(8'h43); send_byte(8'h00);
    send_frame(16'd2, 16'd3, 6'h07, 9'h001, 32'hDEADBEEF, 8'h20, 8'h80, 12, 0);
    idle(3);
    check("resync_hdr_valid", hdr_cnt - b_hdr, 1);
    check("resync_ax", PARAM_ACTIVE_X, 16'd2);
    check("resync_ay", PARAM_ACTIVE_Y, 16'd3);
    check("resync_integ", INTEGRATION, 32'hDEADBEEF);
    check_payload("resync", b_rx, 12, 8'h80);
    check("resync_frame_count", FRAME_COUNT, 16'd2);
    check("resync_err_count", ERR_COUNT, 16'd0);

    // Bad pad byte 27: header rejected, fields held
    b_hdr = hdr_cnt; b_err = err_cnt; b_rx = rx_q.size();
    send_frame(16'd5, 16'd5, 6'h3F, 9'h1FF, 32'd7, 8'h21, 8'h00, 0, 0);
    send_byte(8'h55); send_byte(8'h66);
    idle(3);
    check("badpad_err_pulse", err_cnt - b_err, 1);
    check("badpad_err_count", ERR_COUNT, 16'd1);
    check("badpad_no_hdr", hdr_cnt - b_hdr, 0);
    check("badpad_ax_held", PARAM_ACTIVE_X, 16'd2);
    check("badpad_gain_held", GAIN, 6'h07);
    check("badpad_no_pix", rx_q.size() - b_rx, 0);

    // Backpressure 1-0-0-1 with DIN_VALID gaps
    b_hdr = hdr_cnt; b_done = done_cnt; b_rx = rx_q.size();
    bp_en = 1'b1;
    send_frame(16'd4, 16'd4, 6'h01, 9'h002, 32'd3, 8'h20, 8'h40, 32, 3);
    idle(4);
    bp_en = 1'b0;
    check("bp_hdr_valid", hdr_cnt - b_hdr, 1);
    check_payload("bp", b_rx, 32, 8'h40);
    check("bp_done", done_cnt - b_done, 1);
    check("bp_done_after", beats_at_done - b_rx, 32);
    check("bp_frame_count", FRAME_COUNT, 16'd3);

    // Zero payload: HDR_VALID and FRAME_DONE together, then back-to-back magic
    b_hdr = hdr_cnt; b_done = done_cnt; b_same = same_cnt; b_rx = rx_q.size();
    send_frame(16'd0, 16'd7, 6'h02, 9'h003, 32'd4, 8'h20, 8'h00, 0, 0);
    idle(2);
    check("zero_same_cycle", same_cnt - b_same, 1);
    check("zero_hdr_valid", hdr_cnt - b_hdr, 1);
    check("zero_done", done_cnt - b_done, 1);
    check("zero_no_pix", rx_q.size() - b_rx, 0);
    check("zero_ax", PARAM_ACTIVE_X, 16'd0);
    check("zero_ay", PARAM_ACTIVE_Y, 16'd7);
    check("zero_frame_count", FRAME_COUNT, 16'd4);

    // Reset after 10 payload bytes of a 32-byte frame
    send_frame(16'd4, 16'd4, 6'h09, 9'h009, 32'd9, 8'h20, 8'h00, 10, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    b_hdr = hdr_cnt; b_done = done_cnt; b_rx = rx_q.size();
    DIN = 8'h0A; DIN_VALID = 1'b1;
    @(negedge CLK);
    check("rst2_pix_valid", PIX_VALID, 1'b0);
    check("rst2_din_ready", DIN_READY, 1'b1);
    check("rst2_frame_count", FRAME_COUNT, 16'd0);
    check("rst2_err_count", ERR_COUNT, 16'd0);
    check("rst2_param_ay", PARAM_ACTIVE_Y, 16'd0);
    check("rst2_gain", GAIN, 6'd0);
    check("rst2_integ", INTEGRATION, 32'd0);
    @(posedge CLK); #1;
    for (int i = 11; i < 32; i++) send_byte(8'(i));
    idle(3);
    check("rst2_ignored_pix", rx_q.size() - b_rx, 0);
    check("rst2_ignored_done", done_cnt - b_done, 0);
    check("rst2_ignored_hdr", hdr_cnt - b_hdr, 0);

    // Recovery after reset: 1x1x2 = 2 payload bytes
    b_rx = rx_q.size();
    send_frame(16'd1, 16'd1, 6'h11, 9'h100, 32'd42, 8'h20, 8'hF0, 2, 0);
    idle(3);
    check_payload("recover", b_rx, 2, 8'hF0);
    check("recover_offset", OFFSET, 9'h100);
    check("recover_frame_count", FRAME_COUNT, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
